mem_write_checker: RTL and testbench

- Synthesizable self-check monitor for the pipelined RISC-V core. It watches the data-memory write bus (MemWrite, DataAdr, WriteData).
- Compares observed stores against a programmable ordered list of expected (address, data) pairs. Writes to one configurable scratch address are ignored.
- Reports pass, fail or timeout with a status word, for on-board or emulation runs where $display/$stop are unavailable.
- Sits beside top-level memory, driven by the same nets the core drives into data memory.

---
 rtl/riscv_tb_pkg.sv | 27 ++
 rtl/mem_write_checker_exp_table.sv | 40 ++++
 rtl/mem_write_checker.sv | 130 +++++++++++++
 tb/tb_mem_write_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_tb_pkg.sv
// rtl/riscv_tb_pkg.sv - shared state encoding, default addresses and helpers for the write checker
package riscv_tb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ARMED   = ST_ARMED,
        S_PASS    = ST_PASS,
        S_FAIL    = ST_FAIL,
        S_TIMEOUT = ST_TIMEOUT
    } chk_state_e;

    localparam int DEF_PASS_ADDR    = 100;
    localparam int DEF_PASS_DATA    = 25;
    localparam int DEF_SCRATCH_ADDR = 96;

    // Index width for an n-entry table; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_write_checker_exp_table.sv
// rtl/mem_write_checker_exp_table.sv - expected (address, data) list, one write port, one combinational read port
module exp_table
    import riscv_tb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_EXP = 4,
    parameter int IW      = 2
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [XLEN-1:0] wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [IW:0]     rd_idx_i,
    output logic [XLEN-1:0] rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);

    logic [XLEN-1:0] addr_q [NUM_EXP];
    logic [XLEN-1:0] data_q [NUM_EXP];

    // Table contents survive reset so a test can be re-run without reprogramming.
    always_ff @(posedge clk) begin
        if (we_i && (int'(wr_idx_i) < NUM_EXP)) begin
            addr_q[wr_idx_i] <= wr_addr_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read index reaches NUM_EXP once everything matched; return zero there.
    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        if (int'(rd_idx_i) < NUM_EXP) begin
            rd_addr_o = addr_q[rd_idx_i[IW-1:0]];
            rd_data_o = data_q[rd_idx_i[IW-1:0]];
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - watches data-memory stores against an ordered expected list, reports pass/fail/timeout
module mem_write_checker
    import riscv_tb_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int NUM_EXP        = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    parameter  int STRICT         = 1,
    localparam int IW             = idx_width(NUM_EXP)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [XLEN-1:0] cfg_addr,
    input  logic [XLEN-1:0] cfg_data,
    input  logic            ign_en,
    input  logic [XLEN-1:0] ign_addr,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] DataAdr,
    input  logic [XLEN-1:0] WriteData,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [IW:0]     match_count,
    output logic [XLEN-1:0] fail_addr,
    output logic [XLEN-1:0] fail_data
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW:0]   LAST_MC = (IW + 1)'(NUM_EXP - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    chk_state_e      state_q;
    logic            done_q, pass_q, fail_q, timeout_q;
    logic [IW:0]     mc_q;
    logic [CW-1:0]   cyc_q;
    logic [XLEN-1:0] fail_addr_q, fail_data_q;

    logic [XLEN-1:0] exp_addr, exp_data;
    logic            hit, ignored;

    // The list is frozen while a run is in progress.
    exp_table #(.XLEN(XLEN), .NUM_EXP(NUM_EXP), .IW(IW)) u_exp_table (
        .clk       (clk),
        .we_i      (cfg_we && (state_q != S_ARMED)),
        .wr_idx_i  (cfg_idx),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_idx_i  (mc_q),
        .rd_addr_o (exp_addr),
        .rd_data_o (exp_data)
    );

    // Same-cycle classification of the store; a match wins over the ignore address.
    always_comb begin
        hit     = MemWrite && (DataAdr == exp_addr) && (WriteData == exp_data);
        ignored = MemWrite && ign_en && (DataAdr == ign_addr);
    end

    // Checker FSM with registered status, match counter, timeout counter and fail capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mc_q        <= '0;
            cyc_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (cyc_q != '1) begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                    if (hit) begin
                        mc_q <= mc_q + 1'b1;
                        if (mc_q == LAST_MC) begin
                            state_q <= S_PASS;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else if (cyc_q == TO_LAST) begin
                            state_q   <= S_TIMEOUT;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end else if (MemWrite && !ignored && (STRICT != 0)) begin
                        state_q     <= S_FAIL;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                        fail_addr_q <= DataAdr;
                        fail_data_q <= WriteData;
                    end else if (cyc_q == TO_LAST) begin
                        state_q   <= S_TIMEOUT;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and terminal states hold everything until a start re-arms.
                    if (start) begin
                        state_q     <= S_ARMED;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        mc_q        <= '0;
                        cyc_q       <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                    end
                end
            endcase
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign match_count = mc_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - scoreboard bench for mem_write_checker across three parameterisations
module tb_mem_write_checker;
    import riscv_tb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr, cfg_data, ign_addr, DataAdr, WriteData;
    logic        ign_en, MemWrite;
    logic        start_a, start_b, start_c, cfg_we_a, cfg_we_b, cfg_we_c;

    logic        done_a, pass_a, fail_a, timeout_a;
    logic        done_b, pass_b, fail_b, timeout_b;
    logic        done_c, pass_c, fail_c, timeout_c;
    logic [1:0]  mc_a;
    logic [2:0]  mc_b, mc_c;
    logic [31:0] fa_a, fd_a, fa_b, fd_b, fa_c, fd_c;

    // a: one entry, strict; b: three entries, strict; c: three entries, lenient
    mem_write_checker #(.XLEN(32), .NUM_EXP(1), .TIMEOUT_CYCLES(50), .STRICT(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .cfg_we(cfg_we_a), .cfg_idx(cfg_idx[0:0]),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ign_en(ign_en), .ign_addr(ign_addr),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
        .match_count(mc_a), .fail_addr(fa_a), .fail_data(fd_a));

    mem_write_checker #(.XLEN(32), .NUM_EXP(3), .TIMEOUT_CYCLES(50), .STRICT(1)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .cfg_we(cfg_we_b), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ign_en(ign_en), .ign_addr(ign_addr),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
        .match_count(mc_b), .fail_addr(fa_b), .fail_data(fd_b));

    mem_write_checker #(.XLEN(32), .NUM_EXP(3), .TIMEOUT_CYCLES(200), .STRICT(0)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .cfg_we(cfg_we_c), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ign_en(ign_en), .ign_addr(ign_addr),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done_c), .pass(pass_c), .fail(fail_c), .timeout(timeout_c),
        .match_count(mc_c), .fail_addr(fa_c), .fail_data(fd_c));

    typedef struct {
        string       name;
        int          id;
        bit          chk_cyc;
        int          cyc;
        bit          done, pass, fail, to;
        int          mc;
        logic [31:0] fa, fd;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   probe_req = 1'b0;
    int   probe_id = 0;
    bit   pdone[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int i);
        exp_t        e;
        bit          od, op, of, ot;
        int          omc;
        logic [31:0] ofa, ofd;
        case (i)
            0:       begin od = done_a; op = pass_a; of = fail_a; ot = timeout_a; omc = int'(mc_a); ofa = fa_a; ofd = fd_a; end
            1:       begin od = done_b; op = pass_b; of = fail_b; ot = timeout_b; omc = int'(mc_b); ofa = fa_b; ofd = fd_b; end
            default: begin od = done_c; op = pass_c; of = fail_c; ot = timeout_c; omc = int'(mc_c); ofa = fa_c; ofd = fd_c; end
        endcase
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: dut=%0d done=%0d pass=%0d fail=%0d timeout=%0d cycle=%0d, required no event",
                     i, od, op, of, ot, cyc);
        end else begin
            e = sbq.pop_front();
            if ((e.id != i) || (od != e.done) || (op != e.pass) || (of != e.fail) || (ot != e.to) ||
                (omc != e.mc) || (ofa !== e.fa) || (ofd !== e.fd) || (e.chk_cyc && (cyc != e.cyc))) begin
                miscompares++;
                $display("FAIL %s: got dut=%0d done=%0d pass=%0d fail=%0d timeout=%0d match_count=%0d fail_addr=%0d fail_data=%0d cycle=%0d, required dut=%0d done=%0d pass=%0d fail=%0d timeout=%0d match_count=%0d fail_addr=%0d fail_data=%0d cycle=%0d",
                         e.name, i, od, op, of, ot, omc, ofa, ofd, cyc,
                         e.id, e.done, e.pass, e.fail, e.to, e.mc, e.fa, e.fd, e.chk_cyc ? e.cyc : cyc);
            end
        end
    endtask

    // Monitor: compare on every rising done, or on an explicit probe request.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                bit d;
                d = (i == 0) ? done_a : (i == 1) ? done_b : done_c;
                if (probe_req && (probe_id == i)) check(i);
                else if (d && !pdone[i]) check(i);
                pdone[i] = d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int id, input bit chk, input int c,
                        input bit d, input bit p, input bit f, input bit t,
                        input int mc, input logic [31:0] fa, input logic [31:0] fd);
        exp_t e;
        e.name = name; e.id = id; e.chk_cyc = chk; e.cyc = c;
        e.done = d; e.pass = p; e.fail = f; e.to = t; e.mc = mc; e.fa = fa; e.fd = fd;
        sbq.push_back(e);
    endtask

    task automatic probe(input string name, input int id, input bit d, input bit p,
                         input bit f, input bit t, input int mc,
                         input logic [31:0] fa, input logic [31:0] fd);
        push(name, id, 1'b0, 0, d, p, f, t, mc, fa, fd);
        probe_id  = id;
        probe_req = 1'b1;
        @(negedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic cfg(input int id, input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
        cfg_we_a = (id == 0); cfg_we_b = (id == 1); cfg_we_c = (id == 2);
        tick();
        cfg_we_a = 1'b0; cfg_we_b = 1'b0; cfg_we_c = 1'b0;
    endtask

    task automatic arm(input int id);
        start_a = (id == 0); start_b = (id == 1); start_c = (id == 2);
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        ign_en = 1'b0; ign_addr = '0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cfg_we_a = 1'b0; cfg_we_b = 1'b0; cfg_we_c = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;
        probe("reset_a", 0, 0, 0, 0, 0, 0, 0, 0);
        probe("reset_b", 1, 0, 0, 0, 0, 0, 0, 0);
        probe("reset_c", 2, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        ign_en = 1'b1; ign_addr = DEF_SCRATCH_ADDR;

        // Scratch writes are skipped, then the single entry passes on its own edge.
        cfg(0, 0, DEF_PASS_ADDR, DEF_PASS_DATA);
        arm(0); n = cyc;
        push("ignore_then_pass", 0, 1, n + 3, 1, 1, 0, 0, 1, 0, 0);
        wr(96, 7); wr(96, 9); wr(100, 25); tick();

        // Unexpected store fails and captures; a later correct store changes nothing.
        arm(0); n = cyc;
        push("strict_fail", 0, 1, n + 1, 1, 0, 1, 0, 0, 104, 3);
        wr(104, 3); wr(100, 25); tick();
        probe("fail_hold", 0, 1, 0, 1, 0, 0, 104, 3);

        // Out-of-order store in strict mode.
        cfg(1, 0, 0, 1); cfg(1, 1, 4, 2); cfg(1, 2, 8, 3);
        cfg(2, 0, 0, 1); cfg(2, 1, 4, 2); cfg(2, 2, 8, 3);
        arm(1); n = cyc;
        push("out_of_order", 1, 1, n + 2, 1, 0, 1, 0, 1, 8, 3);
        wr(0, 1); wr(8, 3); tick();

        // Lenient mode skips the out-of-order store and passes on the 4th write.
        arm(2); n = cyc;
        push("lenient_pass", 2, 1, n + 4, 1, 1, 0, 0, 3, 0, 0);
        wr(0, 1); wr(8, 3); wr(4, 2); wr(8, 3); tick();

        // Idle bus: timeout exactly 50 edges after the arming edge.
        arm(0); n = cyc;
        push("timeout_50", 0, 1, n + 50, 1, 0, 0, 1, 0, 0, 0);
        repeat (60) tick();

        // Final match on edge 50 beats the timeout.
        arm(0); n = cyc;
        push("pass_beats_timeout", 0, 1, n + 50, 1, 1, 0, 0, 1, 0, 0);
        repeat (49) tick();
        wr(100, 25); tick();

        // Mid-run reset, re-arm, and start-while-armed is ignored.
        arm(1);
        wr(0, 1);
        probe("partial_match", 1, 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b0; tick(); reset = 1'b1;
        probe("midrun_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        arm(1);
        probe("rearm_clear", 1, 0, 0, 0, 0, 0, 0, 0);
        wr(0, 1);
        arm(1);
        probe("start_while_armed", 1, 0, 0, 0, 0, 1, 0, 0);
        n = cyc;
        push("retained_table_pass", 1, 1, n + 2, 1, 1, 0, 0, 3, 0, 0);
        wr(4, 2); wr(8, 3); tick();

        // Out-of-range index ignored; reconfiguration while armed ignored.
        cfg(0, 1, 300, 300);
        arm(0);
        cfg(0, 0, 200, 5);
        n = cyc;
        push("cfg_locked_armed", 0, 1, n + 1, 1, 1, 0, 0, 1, 0, 0);
        wr(100, 25); tick();

        repeat (3) tick();
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no event from dut=%0d, required done=%0d pass=%0d fail=%0d timeout=%0d",
                     e.name, e.id, e.done, e.pass, e.fail, e.to);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
